spart_word_link: RTL and testbench

//  Parametrised successor to the byte SPART top: full-duplex 8N1 UART that sends/receives whole DATA_W-bit words.
//  TX serialises the word as DATA_W/8 back-to-back frames, byte 0 first; RX reassembles frames into a word.
//  RX raises a level interrupt to the board on each completed word, with overrun and framing-error reporting.

---
 rtl/spart_word_link_if.sv | 36 +++
 rtl/spart_word_link.sv | 256 +++++++++++++++++++++++++
 tb/tb_spart_word_link.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_word_link_if.sv
// Host/pin bundle for spart_word_link: word handshake, RX status and the two serial pins.
// SPART_PARITY_EN adds the parity_err status line.
interface spart_word_link_if #(
  parameter int DATA_W = 32
);
  logic              snd;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              txd;
  logic              rxd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              interrupt_board;
  logic              int_ack;
  logic              rx_overrun;
  logic              frame_err;
`ifdef SPART_PARITY_EN
  logic              parity_err;
`endif

  modport slave (
    input  snd, tx_data, rxd, int_ack,
    output tx_busy, txd, rx_data, rx_valid, interrupt_board, rx_overrun, frame_err
`ifdef SPART_PARITY_EN
    , parity_err
`endif
  );

  modport master (
    output snd, tx_data, rxd, int_ack,
    input  tx_busy, txd, rx_data, rx_valid, interrupt_board, rx_overrun, frame_err
`ifdef SPART_PARITY_EN
    , parity_err
`endif
  );
endinterface

// File: rtl/spart_word_link.sv
// Full-duplex 8N1 UART moving DATA_W-bit words as DATA_W/8 back-to-back frames, byte 0 first.
// Optional feature macro SPART_PARITY_EN: even parity bit after data bit 7, parity_err pulse on RX.
module spart_word_link #(
  parameter int DATA_W   = 32,
  parameter int BAUD_DIV = 434
) (
  input  logic             clk,
  input  logic             rst,
  spart_word_link_if.slave bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCW    = $clog2(BAUD_DIV);
  localparam int NCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_DIV / 2 - 1);
  localparam logic [NCW-1:0] BYTE_LAST = NCW'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAITHI} state_t;

  state_t            tx_state_q;
  logic [BCW-1:0]    tx_baud_q;
  logic [2:0]        tx_bit_q;
  logic [NCW-1:0]    tx_byte_q;
  logic [7:0]        tx_sh_q;
  logic [DATA_W-1:0] tx_word_q;
  logic              tx_par_q;
  logic              txd_q;
  logic              tx_busy_q;

  // ---------------- transmitter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_sh_q    <= '0;
      tx_word_q  <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else if (tx_state_q == S_IDLE) begin
      if (bus.snd) begin
        tx_state_q <= S_START;
        tx_baud_q  <= '0;
        tx_byte_q  <= '0;
        tx_sh_q    <= bus.tx_data[7:0];
        tx_word_q  <= bus.tx_data >> 8;
        txd_q      <= 1'b0;
        tx_busy_q  <= 1'b1;
      end
    end else if (tx_baud_q != BAUD_LAST) begin
      tx_baud_q <= tx_baud_q + 1'b1;
    end else begin
      tx_baud_q <= '0;
      case (tx_state_q)
        S_START: begin
          tx_state_q <= S_DATA;
          tx_bit_q   <= '0;
          txd_q      <= tx_sh_q[0];
          tx_par_q   <= tx_sh_q[0];
          tx_sh_q    <= tx_sh_q >> 1;
        end
        S_DATA: begin
          if (tx_bit_q != 3'd7) begin
            tx_bit_q <= tx_bit_q + 3'd1;
            txd_q    <= tx_sh_q[0];
            tx_par_q <= tx_par_q ^ tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end else begin
`ifdef SPART_PARITY_EN
            tx_state_q <= S_PAR;
            txd_q      <= tx_par_q;
`else
            tx_state_q <= S_STOP;
            txd_q      <= 1'b1;
`endif
          end
        end
        S_PAR: begin
          tx_state_q <= S_STOP;
          txd_q      <= 1'b1;
        end
        S_STOP: begin
          // Next byte's start bit follows the stop bit with no idle gap.
          if (tx_byte_q == BYTE_LAST) begin
            tx_state_q <= S_IDLE;
            tx_busy_q  <= 1'b0;
            txd_q      <= 1'b1;
          end else begin
            tx_state_q <= S_START;
            tx_byte_q  <= tx_byte_q + 1'b1;
            tx_sh_q    <= tx_word_q[7:0];
            tx_word_q  <= tx_word_q >> 8;
            txd_q      <= 1'b0;
          end
        end
        default: begin
          tx_state_q <= S_IDLE;
          tx_busy_q  <= 1'b0;
          txd_q      <= 1'b1;
        end
      endcase
    end
  end

  state_t            rx_state_q;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic [BCW-1:0]    rx_baud_q;
  logic [2:0]        rx_bit_q;
  logic [NCW-1:0]    rx_cnt_q;
  logic [7:0]        rx_sh_q;
  logic              rx_par_q;
  logic [DATA_W-1:0] rx_word_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, irq_q, ovr_q, ferr_q;
  logic              rx_par_bad, rx_stop_tick, rx_done;
  logic [DATA_W-1:0] rx_word_d;

`ifdef SPART_PARITY_EN
  logic perr_q;
  assign rx_par_bad     = rx_par_q;
  assign bus.parity_err = perr_q;
`else
  assign rx_par_bad = 1'b0;
`endif

  assign rx_stop_tick = (rx_state_q == S_STOP) && (rx_baud_q == BAUD_LAST);
  assign rx_done      = rx_stop_tick && rx_s2_q && !rx_par_bad && (rx_cnt_q == BYTE_LAST);
  // Bytes enter at the top and shift down, so byte 0 ends up in bits [7:0].
  assign rx_word_d    = (rx_word_q >> 8) | (DATA_W'(rx_sh_q) << (DATA_W - 8));

  // ---------------- receiver
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_word_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef SPART_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= bus.rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef SPART_PARITY_EN
      perr_q     <= 1'b0;
`endif
      // A completion in the same cycle as an ack wins for the interrupt, loses for overrun.
      if (rx_done)           irq_q <= 1'b1;
      else if (bus.int_ack)  irq_q <= 1'b0;
      if (bus.int_ack)       ovr_q <= 1'b0;
      else if (rx_done && irq_q) ovr_q <= 1'b1;

      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= S_START;
            rx_baud_q  <= '0;
          end
        end
        S_START: begin
          if (rx_baud_q == BAUD_HALF) begin
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_par_q   <= 1'b0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q <= '0;
            rx_sh_q   <= {rx_s2_q, rx_sh_q[7:1]};
            rx_par_q  <= rx_par_q ^ rx_s2_q;
            rx_bit_q  <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
`ifdef SPART_PARITY_EN
              rx_state_q <= S_PAR;
`else
              rx_state_q <= S_STOP;
`endif
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        S_PAR: begin
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q  <= '0;
            rx_par_q   <= rx_par_q ^ rx_s2_q;
            rx_state_q <= S_STOP;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_stop_tick) begin
            rx_baud_q <= '0;
`ifdef SPART_PARITY_EN
            perr_q    <= rx_par_q;
`endif
            if (!rx_s2_q) begin
              ferr_q     <= 1'b1;
              rx_cnt_q   <= '0;
              rx_state_q <= S_WAITHI;
            end else if (rx_par_bad) begin
              rx_cnt_q   <= '0;
              rx_state_q <= S_IDLE;
            end else begin
              rx_word_q  <= rx_word_d;
              rx_state_q <= S_IDLE;
              if (rx_cnt_q == BYTE_LAST) begin
                rx_cnt_q   <= '0;
                rx_data_q  <= rx_word_d;
                rx_valid_q <= 1'b1;
              end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
              end
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        default: begin
          if (rx_s2_q) rx_state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.txd             = txd_q;
  assign bus.tx_busy         = tx_busy_q;
  assign bus.rx_data         = rx_data_q;
  assign bus.rx_valid        = rx_valid_q;
  assign bus.interrupt_board = irq_q;
  assign bus.rx_overrun      = ovr_q;
  assign bus.frame_err       = ferr_q;

endmodule

// File: tb/tb_spart_word_link.sv
// Bench for spart_word_link (DATA_W=32, BAUD_DIV=4): loopback words vs. a frame/word model,
// direct-rxd frame table, glitch rejection, overrun/ack and reset-mid-transmit sequences.
module tb_spart_word_link;
  localparam int DW = 32;
  localparam int BD = 4;
  localparam int NB = DW / 8;
`ifdef SPART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_en = 1'b1;
  logic rxd_drv = 1'b1;

  spart_word_link_if #(.DATA_W(DW)) bus ();
  assign bus.rxd = loop_en ? bus.txd : rxd_drv;

  spart_word_link #(.DATA_W(DW), .BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  logic [31:0] last_word = '0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid   <= n_valid + 1;
      last_word <= bus.rx_data;
    end
    if (bus.frame_err) n_ferr <= n_ferr + 1;
`ifdef SPART_PARITY_EN
    if (bus.parity_err) n_perr <= n_perr + 1;
`endif
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model of the word-level status outputs.
  logic m_irq = 1'b0;
  logic m_ovr = 1'b0;
  int   exp_valid = 0;

  task automatic model_word_done();
    m_ovr = m_ovr | m_irq;
    m_irq = 1'b1;
    exp_valid++;
  endtask

  task automatic do_ack();
    @(posedge clk); #1 bus.int_ack = 1'b1;
    @(posedge clk); #1 bus.int_ack = 1'b0;
    m_irq = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    check("ack_irq", bus.interrupt_board, m_irq);
    check("ack_ovr", bus.rx_overrun, m_ovr);
  endtask

  // Sends one word over txd and compares busy length and the serial waveform to the frame model.
  task automatic send_word(input logic [31:0] w, input bit inject);
    logic exp_q[$];
    logic [7:0] b;
    int n;
    int bad;
    for (int k = 0; k < NB; k++) begin
      b = w[8*k +: 8];
      for (int r = 0; r < BD; r++) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int r = 0; r < BD; r++) exp_q.push_back(b[i]);
`ifdef SPART_PARITY_EN
      for (int r = 0; r < BD; r++) exp_q.push_back(^b);
`endif
      for (int r = 0; r < BD; r++) exp_q.push_back(1'b1);
    end
    @(posedge clk); #1 bus.snd = 1'b1; bus.tx_data = w;
    @(posedge clk); #1 bus.snd = 1'b0; bus.tx_data = $urandom;
    n = 0;
    bad = 0;
    while (n < 4000) begin
      @(negedge clk);
      if (!bus.tx_busy) break;
      if (n >= exp_q.size() || bus.txd !== exp_q[n]) bad++;
      if (inject && n == 40) begin bus.snd = 1'b1; bus.tx_data = 32'hFFFF_FFFF; end
      if (inject && n == 42) bus.snd = 1'b0;
      n++;
    end
    bus.snd = 1'b0;
    check("tx_busy_cycles", n, NB * FB * BD);
    check("txd_bad_bits", bad, 0);
  endtask

  task automatic wait_words(input int target);
    int k = 0;
    while (n_valid < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (12) @(negedge clk);
    check("rx_valid_count", n_valid, target);
  endtask

  // Drives one frame directly on rxd, LSB-first, then leaves the line idle.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic pbit);
    logic [10:0] bits;
    int nb;
`ifdef SPART_PARITY_EN
    bits = {stop, pbit, b, 1'b0};
    nb = 11;
`else
    bits = {1'b0, stop, b, 1'b0};
    nb = 10;
    if (pbit) bits[10] = 1'b0;
`endif
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1 rxd_drv = bits[i];
      repeat (BD - 1) @(posedge clk);
    end
    @(posedge clk); #1 rxd_drv = 1'b1;
    repeat (3 * BD) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        pflip;
    int          exp_ferr;
    int          exp_perr;
    int          exp_valid;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl[16];
  int   n_vec;

  initial begin
    logic [31:0] w;
    int v0, f0, p0;
    bus.snd = 1'b0;
    bus.tx_data = '0;
    bus.int_ack = 1'b0;

    n_vec = 0;
    tbl[n_vec++] = '{8'h55, 1'b0, 1'b0, 1, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h01, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h02, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h03, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h04, 1'b1, 1'b0, 0, 0, 1, 32'h0403_0201};
    tbl[n_vec++] = '{8'hAA, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'hBB, 1'b0, 1'b0, 1, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h11, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h22, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h33, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h44, 1'b1, 1'b0, 0, 0, 1, 32'h4433_2211};
`ifdef SPART_PARITY_EN
    tbl[n_vec++] = '{8'h03, 1'b1, 1'b1, 0, 1, 0, 32'h0};
    tbl[n_vec++] = '{8'h05, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h06, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h07, 1'b1, 1'b0, 0, 0, 0, 32'h0};
    tbl[n_vec++] = '{8'h08, 1'b1, 1'b0, 0, 0, 1, 32'h0807_0605};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", bus.txd, 1);
    check("rst_tx_busy", bus.tx_busy, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_irq", bus.interrupt_board, 0);
    check("rst_overrun", bus.rx_overrun, 0);
    check("rst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Loopback word with an ignored snd during busy
    send_word(32'hA5C3_0F12, 1'b1);
    model_word_done();
    wait_words(exp_valid);
    check("word1_rx_data", bus.rx_data, 32'hA5C3_0F12);
    check("word1_irq", bus.interrupt_board, m_irq);
    check("word1_ovr", bus.rx_overrun, m_ovr);
    check("word1_tx_idle", bus.tx_busy, 0);

    // Second word without ack: overrun
    w = $urandom;
    send_word(w, 1'b0);
    model_word_done();
    wait_words(exp_valid);
    check("ovr_rx_data", bus.rx_data, w);
    check("ovr_irq", bus.interrupt_board, 1);
    check("ovr_flag", bus.rx_overrun, 1);
    do_ack();

    // Randomised loopback words, random ack pattern
    for (int t = 0; t < 6; t++) begin
      w = $urandom;
      send_word(w, bit'($urandom_range(0, 1)));
      model_word_done();
      wait_words(exp_valid);
      check("rand_rx_data", bus.rx_data, w);
      check("rand_irq", bus.interrupt_board, m_irq);
      check("rand_ovr", bus.rx_overrun, m_ovr);
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    do_ack();

    // Direct rxd: 1-cycle glitch must be ignored
    loop_en = 1'b0;
    repeat (8) @(posedge clk);
    v0 = n_valid;
    f0 = n_ferr;
    @(posedge clk); #1 rxd_drv = 1'b0;
    @(posedge clk); #1 rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", n_valid, v0);
    check("glitch_ferr", n_ferr, f0);

    // Direct rxd frame table
    for (int i = 0; i < n_vec; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      p0 = n_perr;
      rx_frame(tbl[i].data, tbl[i].stop, (^tbl[i].data) ^ tbl[i].pflip);
      @(negedge clk);
      check("tbl_frame_err", n_ferr - f0, tbl[i].exp_ferr);
      check("tbl_parity_err", n_perr - p0, tbl[i].exp_perr);
      check("tbl_valid", n_valid - v0, tbl[i].exp_valid);
      if (tbl[i].exp_valid != 0) check("tbl_rx_data", last_word, tbl[i].exp_word);
    end

    // Reset asserted mid-transmit
    loop_en = 1'b1;
    @(posedge clk); #1 bus.snd = 1'b1; bus.tx_data = $urandom;
    @(posedge clk); #1 bus.snd = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_busy_before", bus.tx_busy, 1);
    v0 = n_valid;
    rst = 1'b1;
    #1;
    check("mid_rst_txd", bus.txd, 1);
    check("mid_rst_busy", bus.tx_busy, 0);
    check("mid_rst_rx_valid", bus.rx_valid, 0);
    check("mid_rst_irq", bus.interrupt_board, 0);
    check("mid_rst_ovr", bus.rx_overrun, 0);
    check("mid_rst_rx_data", bus.rx_data, 0);
    check("mid_rst_ferr", bus.frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("no_valid_after_rst", n_valid, v0);
    check("idle_after_rst", bus.tx_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
